// File: rtl/canvas_painter_pkg.sv
// Shared types and constants for the canvas write-side engine.
//   COLOR_WIDTH / COLOR_* : pixel colour encoding; COLOR_NONE is transparent.
//   canvas_op_t           : command opcode (paint a brush square or clear).
//   painter_state_t       : engine state (idle, painting, clearing).
package canvas_painter_pkg;

  localparam int COLOR_WIDTH = 4;

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'h0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'h1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'h2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'h3;

  typedef enum logic {
    OP_PAINT = 1'b0,
    OP_CLEAR = 1'b1
  } canvas_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAINT,
    ST_CLEAR
  } painter_state_t;

endpackage

// File: rtl/canvas_painter_rect_scanner.sv
// Raster walker over an inclusive rectangle [x0..x1] x [y0..y1].
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : latch new bounds and jump to (x0,y0)
//   i_step         : advance one pixel in raster order
//   i_x0/i_x1      : column bounds; i_y0/i_y1 : row bounds
//   o_x/o_y        : current pixel (registered)
//   o_last         : current pixel is (x1,y1)
module rect_scanner #(
  parameter int XW = 3,
  parameter int YW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [XW-1:0] i_x0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y0,
  input  logic [YW-1:0] i_y1,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  logic [XW-1:0] r_x0;
  logic [XW-1:0] r_x1;
  logic [YW-1:0] r_y1;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_x  <= '0;
      r_y  <= '0;
    end else if (i_load) begin
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
      r_x  <= i_x0;
      r_y  <= i_y0;
    end else if (i_step) begin
      if (r_x == r_x1) begin
        r_x <= r_x0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_x == r_x1) && (r_y == r_y1);

endmodule

// File: rtl/canvas_painter.sv
// Write-side engine for one canvas layer: paints clipped square brushes and
// clears the whole layer through a single-pixel write port with backpressure.
//   clk, reset                : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake (ready only when idle)
//   cmd_op/x/y/size/color     : command fields (x/y/color unused for clear)
//   wr_en/wr_ready            : pixel write handshake
//   wr_x/wr_y/wr_color        : registered write address and data
//   busy                      : painting or clearing in progress
module canvas_painter
  import canvas_painter_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int SIZE_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  canvas_op_t                 cmd_op,
  input  logic [$clog2(WIDTH)-1:0]   cmd_x,
  input  logic [$clog2(HEIGHT)-1:0]  cmd_y,
  input  logic [SIZE_W-1:0]          cmd_size,
  input  logic [COLOR_WIDTH-1:0]     cmd_color,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [$clog2(WIDTH)-1:0]   wr_x,
  output logic [$clog2(HEIGHT)-1:0]  wr_y,
  output logic [COLOR_WIDTH-1:0]     wr_color,
  output logic                       busy
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  // Signed working width: room for centre + size plus a sign bit.
  localparam int XCW = ((XW > SIZE_W) ? XW : SIZE_W) + 2;
  localparam int YCW = ((YW > SIZE_W) ? YW : SIZE_W) + 2;

  painter_state_t         r_state;
  painter_state_t         w_nxt_state;
  logic                   r_wr_en;
  logic                   w_nxt_wr_en;
  logic [COLOR_WIDTH-1:0] r_color;
  logic [COLOR_WIDTH-1:0] w_nxt_color;

  logic signed [XCW-1:0]  w_xlo, w_xhi;
  logic signed [YCW-1:0]  w_ylo, w_yhi;
  logic [XW-1:0]          w_px0, w_px1;
  logic [YW-1:0]          w_py0, w_py1;

  logic                   w_load, w_step, w_last;
  logic [XW-1:0]          w_ld_x0, w_ld_x1;
  logic [YW-1:0]          w_ld_y0, w_ld_y1;

  // Brush rectangle clipped to the canvas.
  always_comb begin
    w_xlo = $signed(XCW'(cmd_x)) - $signed(XCW'(cmd_size));
    w_xhi = $signed(XCW'(cmd_x)) + $signed(XCW'(cmd_size));
    w_ylo = $signed(YCW'(cmd_y)) - $signed(YCW'(cmd_size));
    w_yhi = $signed(YCW'(cmd_y)) + $signed(YCW'(cmd_size));
    w_px0 = w_xlo[XCW-1] ? '0 : w_xlo[XW-1:0];
    w_py0 = w_ylo[YCW-1] ? '0 : w_ylo[YW-1:0];
    w_px1 = (w_xhi > $signed(XCW'(WIDTH - 1)))  ? XW'(WIDTH - 1)  : w_xhi[XW-1:0];
    w_py1 = (w_yhi > $signed(YCW'(HEIGHT - 1))) ? YW'(HEIGHT - 1) : w_yhi[YW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_wr_en <= 1'b0;
      r_color <= COLOR_NONE;
    end else begin
      r_state <= w_nxt_state;
      r_wr_en <= w_nxt_wr_en;
      r_color <= w_nxt_color;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_wr_en = r_wr_en;
    w_nxt_color = r_color;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_ld_x0     = '0;
    w_ld_x1     = XW'(WIDTH - 1);
    w_ld_y0     = '0;
    w_ld_y1     = YW'(HEIGHT - 1);
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_load      = 1'b1;
          w_nxt_wr_en = 1'b1;
          if (cmd_op == OP_PAINT) begin
            w_ld_x0     = w_px0;
            w_ld_x1     = w_px1;
            w_ld_y0     = w_py0;
            w_ld_y1     = w_py1;
            w_nxt_color = cmd_color;
            w_nxt_state = ST_PAINT;
          end else begin
            w_nxt_color = COLOR_NONE;
            w_nxt_state = ST_CLEAR;
          end
        end
      end
      ST_PAINT, ST_CLEAR: begin
        if (r_wr_en && wr_ready) begin
          if (w_last) begin
            w_nxt_wr_en = 1'b0;
            w_nxt_state = ST_IDLE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: begin
        w_nxt_wr_en = 1'b0;
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // Scanner registers drive the write address directly, so wr_x/wr_y are
  // registered and stay put while the frame buffer stalls.
  rect_scanner #(
    .XW(XW),
    .YW(YW)
  ) u_scan (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_x0   (w_ld_x0),
    .i_x1   (w_ld_x1),
    .i_y0   (w_ld_y0),
    .i_y1   (w_ld_y1),
    .o_x    (wr_x),
    .o_y    (wr_y),
    .o_last (w_last)
  );

  assign wr_en     = r_wr_en;
  assign wr_color  = r_color;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/canvas_painter.md
Name: canvas_painter

Overview:
- Write-side engine for one canvas layer; the compositor reads canvas pixels, this block writes them.
- Accepts paint and clear commands over a valid/ready handshake.
- A paint command draws a clipped square brush of one color into the canvas frame buffer; a clear command sweeps every pixel to COLOR_NONE (transparent).
- Drives a single-pixel write port with backpressure; one instance per canvas (canvas1..canvas4).

Parameters:
- WIDTH, 640, canvas width in pixels.
- HEIGHT, 480, canvas height in pixels.
- SIZE_W, 4, width of the brush half-size field; max half-size is 2**SIZE_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  canvas_op_t (1)  OP_PAINT or OP_CLEAR.
- cmd_x  in  $clog2(WIDTH)  brush centre x; ignored for clear.
- cmd_y  in  $clog2(HEIGHT)  brush centre y; ignored for clear.
- cmd_size  in  SIZE_W  brush half-size s; square is (2s+1)x(2s+1) before clipping.
- cmd_color  in  COLOR_WIDTH  paint color; ignored for clear.
- wr_en  out  1  write request.
- wr_ready  in  1  frame buffer accepts write this cycle.
- wr_x  out  $clog2(WIDTH)  write x.
- wr_y  out  $clog2(HEIGHT)  write y.
- wr_color  out  COLOR_WIDTH  write data.
- busy  out  1  high in PAINT or CLEAR.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, wr_en=0, wr_x=0, wr_y=0, wr_color=COLOR_NONE, busy=0. cmd_ready=1 once reset deasserts.
- States: IDLE, PAINT, CLEAR.
- IDLE: cmd_ready=1. Handshake occurs when cmd_valid && cmd_ready on a rising edge.
- IDLE->PAINT on a paint handshake:
  - Latch clipped rectangle: x0=max(0,x-s), x1=min(WIDTH-1,x+s), y0=max(0,y-s), y1=min(HEIGHT-1,y+s).
  - Compute with one extra signed bit so underflow/overflow clamps correctly.
  - Latch color; set wr_x=x0, wr_y=y0, wr_en=1.
- IDLE->CLEAR on a clear handshake: wr_x=0, wr_y=0, wr_color=COLOR_NONE, wr_en=1.
- Latency: first write is presented on the cycle after the handshake.
- Write rule:
  - wr_en/wr_x/wr_y/wr_color are registered and held stable while wr_en && !wr_ready.
  - A write completes on a rising edge with wr_en && wr_ready.
  - With wr_ready held high, exactly one pixel is written per cycle.
- Scan order is raster:
  - x increments to x1 (CLEAR: WIDTH-1), then wraps to x0 (CLEAR: 0) and y increments.
  - The write at (x1,y1) (CLEAR: (WIDTH-1,HEIGHT-1)) is last; on its completion wr_en=0 and state=IDLE.
- Pixel count: PAINT writes exactly (x1-x0+1)*(y1-y0+1) pixels; CLEAR writes WIDTH*HEIGHT. No pixel is written twice; no out-of-bounds coordinate is ever driven.
- s=0 writes the single pixel (x,y).
- Commands are never queued. cmd_ready=0 while busy; cmd_valid during busy is ignored and has no side effect. The earliest next handshake is the cycle after the final write completes.
- cmd_x>=WIDTH or cmd_y>=HEIGHT is undefined input; the bench does not drive it.
- Reset mid-operation: aborts immediately to the reset values; no further writes; partial stroke remains in memory.

Decomposition:
- Shared package/common.sv:
  - canvas_op_t enum {OP_PAINT, OP_CLEAR}.
  - Reuse existing COLOR_WIDTH and COLOR_NONE.
- One sub-module, rect_scanner: latches x0/x1/y0/y1, advances on a step pulse, outputs the current (x,y) and a last flag. Used by both PAINT (clipped rect) and CLEAR (full rect).

Test Plan:
- Bench uses WIDTH=8, HEIGHT=8, SIZE_W=2.
- Paint centre: x=4,y=4,s=1,color=COLOR_RED, wr_ready=1 -> 9 writes (3,3),(4,3),(5,3),(3,4)..(5,5) on consecutive cycles, all RED; busy 9 cycles; cmd_ready returns next cycle.
- Corner clip: x=0,y=7,s=2,COLOR_BLUE -> writes only x 0..2, y 5..7 (9 pixels); no coordinate outside 0..7.
- Clear: OP_CLEAR -> 64 writes of COLOR_NONE in raster order (0,0)..(7,7); busy exactly 64 cycles with wr_ready=1.
- Backpressure: paint s=0 at (2,2) with wr_ready low for 3 cycles -> wr_en/wr_x/wr_y/wr_color held for 3 cycles, one write completes at the first edge with wr_ready=1, then IDLE.
- Busy ignore and reset abort:
  - cmd_valid pulsed during a paint -> command ignored, pixel count unchanged.
  - reset=0 mid-clear after 10 writes -> wr_en=0 immediately, state IDLE, cmd_ready=1 after release.
